// File: rtl/round_ctrl.sv
// round_ctrl: game-round engine (switch sync, LFSR target draw, countdown, scoring)
// SCORE_SATURATE_EN: score sticks at 15 instead of wrapping to 0
module round_ctrl #(
    parameter int          TICK_DIV  = 100_000_000,
    parameter logic [7:0]  LFSR_SEED = 8'hA5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [1:0] mod,
    input  logic [7:0] sw,
    output logic [7:0] target,
    output logic [4:0] time_left,
    output logic [3:0] score,
    output logic       match_pulse,
    output logic       busy,
    output logic       game_over
);
    localparam int CW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
    typedef enum logic [1:0] {IDLE, LOAD, PLAY, OVER} state_t;
    state_t state, state_nx;
    logic [1:0]    start_sy;
    logic          start_prev;
    logic [7:0]    sw_s1, sw_sync;
    logic [7:0]    lfsr;
    logic [1:0]    mod_l;
    logic [CW-1:0] cnt;
    logic          start_sync, start_rise, match, tick;
    logic [7:0]    draw;
    logic [3:0]    score_inc;
    function automatic logic [4:0] preload(input logic [1:0] m);
        return m == 2'd0 ? 5'd14 : m == 2'd1 ? 5'd10 : m == 2'd2 ? 5'd8 : 5'd6;
    endfunction
    assign start_sync = start_sy[1];
    assign start_rise = start_sync & ~start_prev;
    assign match      = state == PLAY && sw_sync == target;
    assign tick       = cnt == CW'(TICK_DIV - 1);
    assign draw       = lfsr == sw_sync ? ~lfsr : lfsr;
`ifdef SCORE_SATURATE_EN
    assign score_inc  = score == 4'hF ? score : score + 4'd1;
`else
    assign score_inc  = score + 4'd1;
`endif
    assign busy       = state == LOAD || state == PLAY;
    assign game_over  = state == OVER;
    always_ff @(posedge clk or posedge rst)
        if (rst) state <= IDLE;
        else     state <= state_nx;
    // abort on start low outranks both match and expiry
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = start_rise ? LOAD : IDLE;
            LOAD:    state_nx = PLAY;
            PLAY:    state_nx = !start_sync ? IDLE :
                                (!match && tick && time_left == 5'd1) ? OVER : PLAY;
            OVER:    state_nx = start_sync ? OVER : IDLE;
            default: state_nx = IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            start_sy    <= '0;
            start_prev  <= 1'b0;
            sw_s1       <= '0;
            sw_sync     <= '0;
            lfsr        <= LFSR_SEED;
            mod_l       <= '0;
            cnt         <= '0;
            target      <= '0;
            time_left   <= '0;
            score       <= '0;
            match_pulse <= 1'b0;
        end else begin
            start_sy    <= {start_sy[0], start};
            start_prev  <= start_sync;
            sw_s1       <= sw;
            sw_sync     <= sw_s1;
            lfsr        <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
            match_pulse <= 1'b0;
            case (state)
                IDLE: begin
                    time_left <= preload(mod);
                    score     <= '0;
                    target    <= '0;
                end
                LOAD: begin
                    mod_l     <= mod;
                    score     <= '0;
                    target    <= draw;
                    time_left <= preload(mod);
                    cnt       <= '0;
                end
                PLAY: begin
                    if (!start_sync)
                        score <= '0;
                    else if (match) begin
                        score       <= score_inc;
                        match_pulse <= 1'b1;
                        target      <= draw;
                        time_left   <= preload(mod_l);
                        cnt         <= '0;
                    end else begin
                        cnt <= tick ? '0 : cnt + 1'b1;
                        if (tick) time_left <= time_left - 5'd1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
